// File: rtl/seq_stim_host_if.sv
// Byte-level link between the stimulus host and a UART: transmit byte
// handshake toward the UART and receive byte strobe back from it.
interface seq_stim_host_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       m_valid;
  logic [7:0] m_data;

  modport master (output s_valid, s_data, input s_ready, m_valid, m_data);
  modport slave  (input s_valid, s_data, output s_ready, m_valid, m_data);
endinterface

// File: rtl/seq_stim_host.sv
// Serialises a bit pattern as ASCII '0'/'1' UART bytes (MSB first) and counts
// 'D' replies from the remote sequence detector while a run is in flight.
module seq_stim_host #(
  parameter int PATTERN_LEN  = 8,
  parameter int GAP_CYCLES   = 16,
  parameter int DRAIN_CYCLES = 1024,
  parameter int DCOUNT_W     = 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             start,
  input  logic [PATTERN_LEN-1:0]           pattern_in,
  seq_stim_host_if.master                  bus,
  output logic                             busy,
  output logic                             done,
  output logic [DCOUNT_W-1:0]              detect_count,
  output logic [$clog2(PATTERN_LEN+1)-1:0] first_detect_idx,
  output logic                             first_detect_vld,
  output logic                             rx_other
);
  localparam int IDX_W = $clog2(PATTERN_LEN+1);
  localparam int MAXC  = (GAP_CYCLES > DRAIN_CYCLES) ? GAP_CYCLES : DRAIN_CYCLES;
  localparam int CNT_W = $clog2(MAXC+1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES-1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES-1);
  localparam logic [IDX_W-1:0] LAST_BIT   = IDX_W'(PATTERN_LEN-1);
  localparam logic [7:0]       D_BYTE     = 8'h44;

  typedef enum logic [2:0] {IDLE, LOAD, SEND, GAP, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [PATTERN_LEN-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [DCOUNT_W-1:0]    det_q, det_d;
  logic [IDX_W-1:0]       fdi_q, fdi_d;
  logic                   fdv_q, fdv_d;
  logic                   rxo_q, rxo_d;

  logic       s_valid;
  logic [7:0] s_data;
  logic       accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    if (accept) state_d = (bit_idx_q == LAST_BIT) ? DRAIN : GAP;
      GAP:     if (cnt_q == GAP_LAST) state_d = SEND;
      DRAIN:   if (cnt_q == DRAIN_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The transmitted bit always sits at the top of the shifting pattern copy.
  always_comb begin
    s_valid = (state_q == SEND);
    s_data  = s_valid ? {7'b0011000, pat_q[PATTERN_LEN-1]} : 8'h00;
    busy    = (state_q != IDLE);
    accept  = s_valid && bus.s_ready;
  end

  assign bus.s_valid       = s_valid;
  assign bus.s_data        = s_data;
  assign done              = done_q;
  assign detect_count      = det_q;
  assign first_detect_idx  = fdi_q;
  assign first_detect_vld  = fdv_q;
  assign rx_other          = rxo_q;

  always_comb begin
    pat_d     = pat_q;
    bit_idx_d = bit_idx_q;
    det_d     = det_q;
    fdi_d     = fdi_q;
    fdv_d     = fdv_q;
    rxo_d     = rxo_q;
    cnt_d     = (state_q == GAP || state_q == DRAIN) ? cnt_q + CNT_W'(1) : '0;
    done_d    = (state_q == DRAIN) && (cnt_q == DRAIN_LAST);

    if (state_q == IDLE && start) begin
      pat_d = pattern_in;
      det_d = '0;
      fdi_d = '0;
      fdv_d = 1'b0;
      rxo_d = 1'b0;
    end
    if (state_q == LOAD) bit_idx_d = '0;
    if (accept) begin
      bit_idx_d = bit_idx_q + IDX_W'(1);
      pat_d     = pat_q << 1;
    end

    // Replies are only trusted while a run is active; idle strobes are stale.
    if (busy && bus.m_valid) begin
      if (bus.m_data == D_BYTE) begin
        if (det_q != '1) det_d = det_q + DCOUNT_W'(1);
        if (!fdv_q) begin
          fdi_d = bit_idx_q + IDX_W'(accept);
          fdv_d = 1'b1;
        end
      end else begin
        rxo_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pat_q     <= '0;
      bit_idx_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      det_q     <= '0;
      fdi_q     <= '0;
      fdv_q     <= 1'b0;
      rxo_q     <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      bit_idx_q <= bit_idx_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      det_q     <= det_d;
      fdi_q     <= fdi_d;
      fdv_q     <= fdv_d;
      rxo_q     <= rxo_d;
    end
  end
endmodule

// File: tb/tb_seq_stim_host.sv
// Directed bench: a short-pattern instance for serialisation/control cases and
// an 8-bit instance looped back through a behavioural 0110 detector.
module tb_seq_stim_host;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  seq_stim_host_if ifa ();
  seq_stim_host_if ifb ();

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] pat_a = '0;
  logic [7:0] pat_b = '0;
  logic       busy_a, done_a, fdv_a, rxo_a;
  logic [1:0] dc_a;
  logic [2:0] fdi_a;
  logic       busy_b, done_b, fdv_b, rxo_b;
  logic [7:0] dc_b;
  logic [3:0] fdi_b;

  seq_stim_host #(.PATTERN_LEN(4), .GAP_CYCLES(3), .DRAIN_CYCLES(8), .DCOUNT_W(2)) dut_a (
    .clk(clk), .rstn(rstn), .start(start_a), .pattern_in(pat_a), .bus(ifa),
    .busy(busy_a), .done(done_a), .detect_count(dc_a), .first_detect_idx(fdi_a),
    .first_detect_vld(fdv_a), .rx_other(rxo_a));

  seq_stim_host #(.PATTERN_LEN(8), .GAP_CYCLES(3), .DRAIN_CYCLES(8), .DCOUNT_W(8)) dut_b (
    .clk(clk), .rstn(rstn), .start(start_b), .pattern_in(pat_b), .bus(ifb),
    .busy(busy_b), .done(done_b), .detect_count(dc_b), .first_detect_idx(fdi_b),
    .first_detect_vld(fdv_b), .rx_other(rxo_b));

  int         cyc;
  logic [7:0] acc_d[$];
  int         acc_c[$];
  int         done_c;
  logic       done_busy;

  // Records handshakes/done seen at this negedge, then advances one cycle.
  task automatic step_a();
    if (ifa.s_valid && ifa.s_ready) begin
      acc_d.push_back(ifa.s_data);
      acc_c.push_back(cyc);
    end
    if (done_a) begin
      done_c = cyc;
      done_busy = busy_a;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic step_b();
    if (ifb.s_valid && ifb.s_ready) begin
      acc_d.push_back(ifb.s_data);
      acc_c.push_back(cyc);
    end
    if (done_b) begin
      done_c = cyc;
      done_busy = busy_b;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic start_run_a(input logic [3:0] p);
    acc_d.delete(); acc_c.delete(); done_c = -1; cyc = 0;
    pat_a = p; start_a = 1'b1;
    step_a();
    start_a = 1'b0;
  endtask

  task automatic test_reset();
    ifa.s_ready = 1'b1; ifa.m_valid = 1'b0; ifa.m_data = 8'h00;
    ifb.s_ready = 1'b1; ifb.m_valid = 1'b0; ifb.m_data = 8'h00;
    rstn = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({ifa.s_valid, ifa.s_data, busy_a, done_a, dc_a, fdi_a, fdv_a, rxo_a} !== 18'h0) begin
      failures++;
      $display("FAIL reset_a: got %h expected 0", {ifa.s_valid, ifa.s_data, busy_a, done_a, dc_a, fdi_a, fdv_a, rxo_a});
    end
    checks++;
    if ({ifb.s_valid, ifb.s_data, busy_b, done_b, dc_b, fdi_b, fdv_b, rxo_b} !== 25'h0) begin
      failures++;
      $display("FAIL reset_b: got %h expected 0", {ifb.s_valid, ifb.s_data, busy_b, done_b, dc_b, fdi_b, fdv_b, rxo_b});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] exp [4] = '{8'h30, 8'h31, 8'h31, 8'h30};
    logic [7:0] got;
    ifa.s_ready = 1'b1;
    start_run_a(4'b0110);
    checks++;
    if ({busy_a, ifa.s_valid} !== 2'b10) begin
      failures++; $display("FAIL basic_load: busy,s_valid got %b expected 10", {busy_a, ifa.s_valid});
    end
    step_a();
    checks++;
    if ({ifa.s_valid, ifa.s_data} !== 9'h130) begin
      failures++; $display("FAIL basic_first_byte: got %h expected 130", {ifa.s_valid, ifa.s_data});
    end
    while (done_c < 0 && cyc < 60) begin
      if (cyc == 3) pat_a = 4'b1111;
      step_a();
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < acc_d.size()) ? acc_d[i] : 8'hxx;
      checks++;
      if (got !== exp[i]) begin
        failures++; $display("FAIL basic_byte%0d: got %h expected %h", i, got, exp[i]);
      end
      checks++;
      if (i < acc_c.size() && acc_c[i] != 2 + 4*i || i >= acc_c.size()) begin
        failures++; $display("FAIL basic_spacing%0d: got cycle %0d expected %0d", i, (i < acc_c.size()) ? acc_c[i] : -1, 2 + 4*i);
      end
    end
    checks++;
    if (acc_d.size() != 4) begin
      failures++; $display("FAIL basic_accepts: got %0d expected 4", acc_d.size());
    end
    checks++;
    if (done_c != 23 || done_busy !== 1'b0) begin
      failures++; $display("FAIL basic_done: got cycle %0d busy %b expected 23 busy 0", done_c, done_busy);
    end
    checks++;
    if ({done_a, dc_a, fdv_a, rxo_a} !== 5'b0) begin
      failures++; $display("FAIL basic_results: done,dc,fdv,rxo got %b expected 00000", {done_a, dc_a, fdv_a, rxo_a});
    end
  endtask

  task automatic test_backpressure();
    start_run_a(4'b0110);
    while (done_c < 0 && cyc < 60) begin
      ifa.s_ready = !(cyc >= 6 && cyc <= 10);
      if (cyc >= 6 && cyc <= 10) begin
        checks++;
        if ({ifa.s_valid, ifa.s_data} !== 9'h131) begin
          failures++; $display("FAIL bp_hold_c%0d: got %h expected 131", cyc, {ifa.s_valid, ifa.s_data});
        end
      end
      step_a();
    end
    ifa.s_ready = 1'b1;
    checks++;
    if (acc_d.size() != 4 || acc_c[1] != 11 || acc_c[3] != 19) begin
      failures++; $display("FAIL bp_accepts: got n=%0d c1=%0d c3=%0d expected 4 11 19", acc_d.size(), acc_c[1], acc_c[3]);
    end
    checks++;
    if ({acc_d[0], acc_d[1], acc_d[2], acc_d[3]} !== 32'h30313130) begin
      failures++; $display("FAIL bp_bytes: got %h expected 30313130", {acc_d[0], acc_d[1], acc_d[2], acc_d[3]});
    end
    checks++;
    if (done_c != 28) begin
      failures++; $display("FAIL bp_done: got %0d expected 28", done_c);
    end
  endtask

  task automatic test_loopback();
    logic [3:0] hist = '0;
    int reply_at = -1;
    acc_d.delete(); acc_c.delete(); done_c = -1; cyc = 0;
    ifb.s_ready = 1'b1; ifb.m_data = 8'h44;
    pat_b = 8'b0110_0110; start_b = 1'b1;
    step_b();
    start_b = 1'b0;
    while (done_c < 0 && cyc < 100) begin
      ifb.m_valid = (cyc == reply_at);
      if (ifb.s_valid && ifb.s_ready) begin
        hist = {hist[2:0], ifb.s_data[0]};
        if (hist == 4'b0110) reply_at = cyc + 2;
      end
      step_b();
    end
    ifb.m_valid = 1'b0;
    checks++;
    if (acc_d.size() != 8 || done_c != 39) begin
      failures++; $display("FAIL loop_run: got n=%0d done=%0d expected 8 39", acc_d.size(), done_c);
    end
    checks++;
    if (dc_b !== 8'd2) begin
      failures++; $display("FAIL loop_count: got %0d expected 2", dc_b);
    end
    checks++;
    if ({fdv_b, fdi_b} !== 5'b1_0100) begin
      failures++; $display("FAIL loop_first: vld,idx got %b expected 10100", {fdv_b, fdi_b});
    end
    checks++;
    if (rxo_b !== 1'b0) begin
      failures++; $display("FAIL loop_rx_other: got %b expected 0", rxo_b);
    end
  endtask

  task automatic test_saturation();
    start_run_a(4'b0000);
    while (done_c < 0 && cyc < 60) begin
      ifa.m_valid = (cyc >= 15 && cyc <= 20);
      ifa.m_data  = (cyc == 20) ? 8'h41 : 8'h44;
      if (cyc == 17) begin
        checks++;
        if (dc_a !== 2'd2) begin
          failures++; $display("FAIL sat_mid: got %0d expected 2", dc_a);
        end
      end
      step_a();
    end
    ifa.m_valid = 1'b0;
    checks++;
    if ({dc_a, rxo_a} !== 3'b11_1) begin
      failures++; $display("FAIL sat_count: dc,rxo got %b expected 111", {dc_a, rxo_a});
    end
    checks++;
    if ({fdv_a, fdi_a, done_c == 23} !== 5'b1_100_1) begin
      failures++; $display("FAIL sat_first: vld,idx got %b%b done %0d expected 1100 done 23", fdv_a, fdi_a, done_c);
    end
  endtask

  task automatic test_start_busy();
    start_run_a(4'b0110);
    checks++;
    if ({dc_a, fdv_a, rxo_a} !== 4'b0) begin
      failures++; $display("FAIL sb_clear: dc,fdv,rxo got %b expected 0000", {dc_a, fdv_a, rxo_a});
    end
    while (cyc < 28) begin
      ifa.m_valid = (cyc == 3 || cyc == 22 || cyc == 23 || cyc == 25);
      ifa.m_data  = 8'h44;
      if (cyc == 8) begin start_a = 1'b1; pat_a = 4'b1001; end
      else start_a = 1'b0;
      if (cyc == 4) begin
        checks++;
        if ({dc_a, fdv_a, fdi_a} !== 6'b01_1_001) begin
          failures++; $display("FAIL sb_first: dc,vld,idx got %b expected 011001", {dc_a, fdv_a, fdi_a});
        end
      end
      if (cyc == 9) begin
        checks++;
        if ({busy_a, dc_a} !== 3'b1_01) begin
          failures++; $display("FAIL sb_no_clear: busy,dc got %b expected 101", {busy_a, dc_a});
        end
      end
      if (cyc == 23) begin
        checks++;
        if ({done_a, dc_a} !== 3'b1_10) begin
          failures++; $display("FAIL sb_done_edge: done,dc got %b expected 110", {done_a, dc_a});
        end
      end
      step_a();
    end
    ifa.m_valid = 1'b0;
    checks++;
    if (acc_d.size() != 4 || {acc_d[0], acc_d[1], acc_d[2], acc_d[3]} !== 32'h30313130) begin
      failures++; $display("FAIL sb_no_relatch: got n=%0d bytes %h expected 4 30313130", acc_d.size(), {acc_d[0], acc_d[1], acc_d[2], acc_d[3]});
    end
    checks++;
    if (dc_a !== 2'd2 || busy_a !== 1'b0) begin
      failures++; $display("FAIL sb_idle_ignored: dc %0d busy %b expected 2 0", dc_a, busy_a);
    end
  endtask

  task automatic test_reset_midrun();
    start_run_a(4'b1010);
    while (cyc < 10) begin
      ifa.m_valid = (cyc == 5 || cyc == 7);
      ifa.m_data  = (cyc == 7) ? 8'h41 : 8'h44;
      step_a();
    end
    ifa.m_valid = 1'b0;
    checks++;
    if ({ifa.s_valid, ifa.s_data, dc_a, fdi_a, rxo_a} !== {9'h131, 2'd1, 3'd1, 1'b1}) begin
      failures++; $display("FAIL rst_pre: got %h expected %h", {ifa.s_valid, ifa.s_data, dc_a, fdi_a, rxo_a}, {9'h131, 2'd1, 3'd1, 1'b1});
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({ifa.s_valid, ifa.s_data, busy_a, done_a, dc_a, fdi_a, fdv_a, rxo_a} !== 18'h0) begin
      failures++; $display("FAIL rst_async: got %h expected 0", {ifa.s_valid, ifa.s_data, busy_a, done_a, dc_a, fdi_a, fdv_a, rxo_a});
    end
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_run_a(4'b1100);
    while (done_c < 0 && cyc < 60) step_a();
    checks++;
    if (acc_d.size() != 4 || acc_c[0] != 2 || {acc_d[0], acc_d[1], acc_d[2], acc_d[3]} !== 32'h31313030) begin
      failures++; $display("FAIL rst_restart: got n=%0d c0=%0d bytes %h expected 4 2 31313030", acc_d.size(), acc_c[0], {acc_d[0], acc_d[1], acc_d[2], acc_d[3]});
    end
    checks++;
    if (done_c != 23) begin
      failures++; $display("FAIL rst_restart_done: got %0d expected 23", done_c);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_loopback();
    test_saturation();
    test_start_busy();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_stim_host.md
# seq_stim_host

Host-side stimulus and response block for the 0110 sequence-detector link. It serialises a parallel bit pattern into UART bytes, one bit per byte as ASCII '0' or '1', and hands them to a `uart` instance's transmit byte interface. It also watches that instance's receive byte interface for 'D' (0x44) replies from the detector end, counting them. It sits on the host/test board and drives the detector board's `rx`, enabling closed-loop self-test of the detector over the real serial link.

## Interface
- `PATTERN_LEN`, 8: number of bits sent per run.
- `GAP_CYCLES`, 16: idle cycles after each accepted byte before the next byte is offered (≥1).
- `DRAIN_CYCLES`, 1024: cycles to keep listening after the last accepted byte before `done` (≥1).
- `DCOUNT_W`, 8: width of the detection counter.

- `clk`  in  1: system clock; the block has one clock.
- `rstn`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request to begin a run; sampled only in IDLE.
- `pattern_in`  in  PATTERN_LEN: pattern, latched on an accepted `start`; bit PATTERN_LEN-1 is sent first.
- `s_valid`  out  1: byte valid to the UART transmitter.
- `s_data`  out  8: byte to transmit.
- `s_ready`  in  1: UART transmitter ready.
- `m_valid`  in  1: single-cycle pulse from the UART receiver, byte available.
- `m_data`  in  8: received byte.
- `busy`  out  1: high from the cycle after an accepted `start` until `done`.
- `done`  out  1: single-cycle pulse at the end of a run.
- `detect_count`  out  DCOUNT_W: number of 0x44 bytes received during the current or last run; saturating.
- `first_detect_idx`  out  $clog2(PATTERN_LEN+1): number of bytes accepted when the first 'D' arrived.
- `first_detect_vld`  out  1: `first_detect_idx` holds a valid value.
- `rx_other`  out  1: sticky flag; a non-0x44 byte was received during the run.

## Operation
- Byte encoding: bit b is sent as 0x30 | b, so the LSB carries the bit.
- FSM states:
  - IDLE: `start` → LOAD.
  - LOAD: latch the pattern, clear `bit_idx`; → SEND.
  - SEND: `s_valid`=1; on `s_valid && s_ready` → GAP if bits remain, else → DRAIN.
  - GAP: count GAP_CYCLES; → SEND.
  - DRAIN: count DRAIN_CYCLES; → IDLE with `done`=1.
- Handshake: `s_data` is driven from the latched pattern and held stable while `s_valid`=1 and `s_ready`=0. `s_valid` drops the cycle after acceptance. There is never more than one accept per byte.
- On an accepted `start`: clear `detect_count`, `first_detect_vld`, `first_detect_idx`, and `rx_other`.
- Receive monitoring is active only in LOAD, SEND, GAP, and DRAIN. In IDLE, `m_valid` is ignored, so stale replies are not counted.
- On `m_valid` with `m_data`==0x44:
  - `detect_count` += 1, saturating at all-ones.
  - If `first_detect_vld`=0: set `first_detect_idx` to the count of bytes accepted so far, including an accept in the same cycle, and set `first_detect_vld`.
- On `m_valid` with any other byte: set `rx_other`; `detect_count` is unchanged.
- `start` while busy is ignored; no relatch and no clearing.
- `pattern_in` changes after latch have no effect on the current run.
- Results hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: `s_valid`=0, `s_data`=0x00, `busy`=0, `done`=0, `detect_count`=0, `first_detect_idx`=0, `first_detect_vld`=0, `rx_other`=0; FSM in IDLE.
- Reset applies asynchronously at any point, including mid-byte or with `s_valid` high. `s_valid` drops immediately on reset.
- `start` high at cycle t (in IDLE) gives:
  - LOAD at t+1 with `busy`=1.
  - `s_valid`=1 with the first byte at t+2.
- Accept at cycle a gives:
  - `s_valid`=0 for cycles a+1 .. a+GAP_CYCLES.
  - Next byte valid at a+GAP_CYCLES+1.
- Last accept at cycle L gives `done`=1 and `busy`=0 at cycle L+DRAIN_CYCLES+1, and IDLE from then on.
- Counter updates from `m_valid` are registered and visible the cycle after the pulse.
- `m_valid` in the same cycle as the `done` transition is counted; `m_valid` one cycle later is ignored.

## Test plan
- **Basic serialisation.** PATTERN_LEN=4, `pattern_in`=4'b0110, `s_ready` tied high, GAP_CYCLES=3 → accepted bytes are 0x30, 0x31, 0x31, 0x30, spaced 4 cycles apart; `done` at L+DRAIN_CYCLES+1; `detect_count`=0; `first_detect_vld`=0.
- **Backpressure.** Hold `s_ready` low for 5 cycles during byte 2 → `s_data`=0x31 stable and `s_valid` high throughout; exactly 4 accepts total.
- **Loopback with detector model.** The model replies 'D' after each 0110. Use PATTERN_LEN=8, `pattern_in`=8'b0110_0110 → `detect_count`=2, `first_detect_idx`=4, `first_detect_vld`=1, `rx_other`=0.
- **Foreign byte and saturation.** DCOUNT_W=2; inject 5×0x44 plus 1×0x41 during DRAIN → `detect_count`=3, `rx_other`=1.
- **Start while busy, and idle replies.** A second `start` mid-run causes no relatch and no clear. 0x44 injected while in IDLE → `detect_count` unchanged.
- **Reset mid-run.** Deassert `rstn` while `s_valid`=1 in byte 3 → all outputs at reset values immediately. A new `start` after release sends from bit PATTERN_LEN-1.
